// File: rtl/scan_chk_pkg.sv
// Shared types and helpers for the scan response checker.
//   state_t        : checker FSM states
//   bit_cnt_width  : width of a counter that must hold the values 0..ff
package scan_chk_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    function automatic int unsigned bit_cnt_width(input int unsigned ff);
        return $clog2(ff + 1);
    endfunction

endpackage

// File: rtl/scan_unload_shreg.sv
// Serial-in unload register for one scan window.
// Bits enter at the LSB and move toward the MSB, so the first bit shifted in
// sits at the MSB once FF bits have arrived.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear
//   load_clr   : clear at the start of a new window
//   shift, din : shift enable and serial data
//   data       : captured unload bits
//   count      : bits shifted since the last clear
//   full       : FF bits have been shifted
module scan_unload_shreg
    import scan_chk_pkg::*;
#(
    parameter int unsigned FF = 25,
    localparam int unsigned BCW = bit_cnt_width(FF)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clr,
    input  logic           load_clr,
    input  logic           shift,
    input  logic           din,
    output logic [FF-1:0]  data,
    output logic [BCW-1:0] count,
    output logic           full
);

    localparam logic [BCW-1:0] LAST_BIT = BCW'(FF - 1);

    // Shift register, bit counter and full flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data  <= '0;
            count <= '0;
            full  <= 1'b0;
        end else if (clr || load_clr) begin
            data  <= '0;
            count <= '0;
            full  <= 1'b0;
        end else if (shift) begin
            // Truncating the concatenation drops the old MSB; works for FF=1 too
            data  <= FF'({data, din});
            count <= count + BCW'(1);
            full  <= (count == LAST_BIT);
        end
    end

endmodule

// File: rtl/scan_response_checker.sv
// Scan response checker: deserializes So during shift, samples PO on the
// capture cycle and compares both against an expected record per window.
//   clk, rst_n, clr           : clock, async reset, synchronous clear
//   NbarT, So, PO             : scan enable, scan-out and primary outputs of the CUT
//   exp_valid/exp_ready       : expected record handshake
//   exp_so, exp_po            : expected unload (MSB first out) and capture values
//   chk_so, chk_po, cap       : per-window compare enables and capture presence
//   res_valid, res_fail       : one-cycle window result
//   pattern_count, fail_count : completed / failing windows (saturating)
//   first_fail_idx, any_fail  : index of the first failing window, sticky fail
//   proto_err                 : sticky NbarT protocol violation
module scan_response_checker
    import scan_chk_pkg::*;
#(
    parameter int unsigned FF        = 25,
    parameter int unsigned OUT_WIDTH = 6,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 NbarT,
    input  logic                 So,
    input  logic [OUT_WIDTH-1:0] PO,
    input  logic                 exp_valid,
    output logic                 exp_ready,
    input  logic [FF-1:0]        exp_so,
    input  logic [OUT_WIDTH-1:0] exp_po,
    input  logic                 chk_so,
    input  logic                 chk_po,
    input  logic                 cap,
    output logic                 res_valid,
    output logic                 res_fail,
    output logic [CNT_WIDTH-1:0] pattern_count,
    output logic [CNT_WIDTH-1:0] fail_count,
    output logic [CNT_WIDTH-1:0] first_fail_idx,
    output logic                 any_fail,
    output logic                 proto_err
);

    localparam int unsigned          BCW      = bit_cnt_width(FF);
    localparam logic [BCW-1:0]       LAST_BIT = BCW'(FF - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    state_t                 state;
    logic [FF-1:0]          exp_so_q;
    logic [OUT_WIDTH-1:0]   exp_po_q;
    logic [OUT_WIDTH-1:0]   po_q;
    logic                   chk_so_q;
    logic                   chk_po_q;
    logic                   cap_q;
    logic                   abort_q;

    logic [FF-1:0]          unload;
    logic [BCW-1:0]         bit_cnt;
    logic                   full;
    logic                   accept;
    logic                   shift_en;
    logic                   window_fail;

    assign accept      = (state == IDLE) && exp_valid && exp_ready;
    assign shift_en    = (state == SHIFT) && NbarT && !full;
    assign window_fail = (chk_so_q && (unload != exp_so_q))
                       | (chk_po_q && (po_q != exp_po_q))
                       | abort_q;

    scan_unload_shreg #(
        .FF (FF)
    ) u_shreg (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .load_clr (accept),
        .shift    (shift_en),
        .din      (So),
        .data     (unload),
        .count    (bit_cnt),
        .full     (full)
    );

    // Window FSM, result pulse and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            exp_ready      <= 1'b1;
            res_valid      <= 1'b0;
            res_fail       <= 1'b0;
            pattern_count  <= '0;
            fail_count     <= '0;
            first_fail_idx <= '1;
            any_fail       <= 1'b0;
            proto_err      <= 1'b0;
            exp_so_q       <= '0;
            exp_po_q       <= '0;
            po_q           <= '0;
            chk_so_q       <= 1'b0;
            chk_po_q       <= 1'b0;
            cap_q          <= 1'b0;
            abort_q        <= 1'b0;
        end else if (clr) begin
            state          <= IDLE;
            exp_ready      <= 1'b1;
            res_valid      <= 1'b0;
            res_fail       <= 1'b0;
            pattern_count  <= '0;
            fail_count     <= '0;
            first_fail_idx <= '1;
            any_fail       <= 1'b0;
            proto_err      <= 1'b0;
            abort_q        <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            res_fail  <= 1'b0;
            case (state)
                IDLE: begin
                    // Shift edges outside a window are discarded but flagged
                    if (NbarT) begin
                        proto_err <= 1'b1;
                    end
                    if (accept) begin
                        exp_so_q  <= exp_so;
                        exp_po_q  <= exp_po;
                        chk_so_q  <= chk_so;
                        chk_po_q  <= chk_po;
                        cap_q     <= cap;
                        po_q      <= '0;
                        abort_q   <= 1'b0;
                        exp_ready <= 1'b0;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (NbarT) begin
                        if (bit_cnt == LAST_BIT) begin
                            state <= cap_q ? CAPTURE : DONE;
                        end
                    end else begin
                        // Early capture: the unload is incomplete
                        proto_err <= 1'b1;
                        abort_q   <= 1'b1;
                        state     <= DONE;
                    end
                end
                CAPTURE: begin
                    if (!NbarT) begin
                        po_q  <= PO;
                        state <= DONE;
                    end else begin
                        proto_err <= 1'b1;
                    end
                end
                DONE: begin
                    res_valid <= 1'b1;
                    res_fail  <= window_fail;
                    if (pattern_count != CNT_MAX) begin
                        pattern_count <= pattern_count + CNT_WIDTH'(1);
                    end
                    if (window_fail) begin
                        if (fail_count != CNT_MAX) begin
                            fail_count <= fail_count + CNT_WIDTH'(1);
                        end
                        if (!any_fail) begin
                            first_fail_idx <= pattern_count;
                            any_fail       <= 1'b1;
                        end
                    end
                    exp_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    exp_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scan_response_checker.sv
// Randomized bench for scan_response_checker with a transaction-level model:
// each window's expected verdict comes from the bits and PO actually driven,
// and a per-cycle compare process checks the result pulse and counters.
module tb_scan_response_checker;

    localparam int unsigned FF = 25;
    localparam int unsigned OW = 6;
    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr = 1'b0;
    logic          NbarT = 1'b0;
    logic          So = 1'b0;
    logic [OW-1:0] PO = '0;
    logic          exp_valid = 1'b0;
    logic          exp_ready;
    logic [FF-1:0] exp_so = '0;
    logic [OW-1:0] exp_po = '0;
    logic          chk_so = 1'b0;
    logic          chk_po = 1'b0;
    logic          cap = 1'b0;
    logic          res_valid;
    logic          res_fail;
    logic [CW-1:0] pattern_count;
    logic [CW-1:0] fail_count;
    logic [CW-1:0] first_fail_idx;
    logic          any_fail;
    logic          proto_err;

    scan_response_checker #(
        .FF        (FF),
        .OUT_WIDTH (OW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .clr            (clr),
        .NbarT          (NbarT),
        .So             (So),
        .PO             (PO),
        .exp_valid      (exp_valid),
        .exp_ready      (exp_ready),
        .exp_so         (exp_so),
        .exp_po         (exp_po),
        .chk_so         (chk_so),
        .chk_po         (chk_po),
        .cap            (cap),
        .res_valid      (res_valid),
        .res_fail       (res_fail),
        .pattern_count  (pattern_count),
        .fail_count     (fail_count),
        .first_fail_idx (first_fail_idx),
        .any_fail       (any_fail),
        .proto_err      (proto_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    logic clr_at_edge = 1'b0;

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        clr_at_edge <= clr;
    end

    typedef struct {
        int due;
        bit fail;
    } exp_t;

    exp_t q[$];
    exp_t e;
    logic [CW-1:0] m_pat, m_fail, m_first;
    logic          m_any;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act === expv) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Per-cycle compare against the window model
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_pat = '0; m_fail = '0; m_first = '1; m_any = 1'b0;
        end else if (clr_at_edge) begin
            q.delete();
            m_pat = '0; m_fail = '0; m_first = '1; m_any = 1'b0;
            check("clr_no_result", res_valid, 0);
        end else if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            if (e.fail) begin
                if (!m_any) m_first = m_pat;
                m_any = 1'b1;
                if (m_fail != '1) m_fail = m_fail + 1'b1;
            end
            if (m_pat != '1) m_pat = m_pat + 1'b1;
            check("res_valid", res_valid, 1);
            check("res_fail", res_fail, 32'(e.fail));
            check("pattern_count", pattern_count, 32'(m_pat));
            check("fail_count", fail_count, 32'(m_fail));
            check("first_fail_idx", first_fail_idx, 32'(m_first));
            check("any_fail", any_fail, 32'(m_any));
        end else begin
            check("res_valid_idle", res_valid, 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic send_record(input logic [FF-1:0] so_v, input logic [OW-1:0] po_v,
                               input bit c_so, input bit c_po, input bit c_cap);
        bit accepted;
        accepted  = 1'b0;
        exp_so    = so_v;
        exp_po    = po_v;
        chk_so    = c_so;
        chk_po    = c_po;
        cap       = c_cap;
        NbarT     = 1'b0;
        exp_valid = 1'b1;
        for (int i = 0; i < 20 && !accepted; i++) begin
            if (exp_ready) accepted = 1'b1;
            tick();
        end
        exp_valid = 1'b0;
        check("record_accepted", 32'(accepted), 1);
    endtask

    task automatic shift_bits(input logic [FF-1:0] stream, input int n);
        for (int i = 0; i < n; i++) begin
            NbarT = 1'b1;
            So    = stream[FF-1-i];
            tick();
        end
    endtask

    // One window; returns right after the completing sample edge
    task automatic run_window(input logic [FF-1:0] exp_so_v, input logic [FF-1:0] stream,
                              input logic [OW-1:0] exp_po_v, input logic [OW-1:0] po_v,
                              input bit c_so, input bit c_po, input bit c_cap,
                              input int abort_at, input int overshift);
        bit f;
        send_record(exp_so_v, exp_po_v, c_so, c_po, c_cap);
        if (abort_at >= 0 && abort_at < int'(FF)) begin
            shift_bits(stream, abort_at);
            NbarT = 1'b0;
            tick();
            f = 1'b1;
        end else begin
            shift_bits(stream, FF);
            if (c_cap) begin
                for (int i = 0; i < overshift; i++) begin
                    NbarT = 1'b1;
                    So    = 1'($urandom);
                    tick();
                end
                NbarT = 1'b0;
                PO    = po_v;
                tick();
            end
            f = (c_so && stream != exp_so_v) || (c_po && po_v != exp_po_v);
        end
        NbarT = 1'b0;
        q.push_back('{due: cyc + 1, fail: f});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [FF-1:0] s, st;
        logic [OW-1:0] ep, pv;
        bit            cs, cp, cc;
        int            ab, ov, idx;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_exp_ready", exp_ready, 1);
        check("rst_res_valid", res_valid, 0);
        check("rst_pattern_count", pattern_count, 0);
        check("rst_first_fail_idx", first_fail_idx, 32'hFFFF);
        check("rst_proto_err", proto_err, 0);
        rst_n = 1'b1;
        tick();

        // 1: passing capture window, unload not compared
        s = FF'($urandom);
        run_window(s, ~s, 6'h2A, 6'h2A, 1'b0, 1'b1, 1'b1, -1, 0);
        check("t1_not_yet", res_valid, 0);
        tick();
        check("t1_valid", res_valid, 1);
        check("t1_fail", res_fail, 0);
        check("t1_pattern_count", pattern_count, 1);
        check("t1_fail_count", fail_count, 0);

        // 2: unload mismatch on bit 7
        do_clr();
        s  = 25'h155_5555;
        st = s;
        st[7] = ~st[7];
        run_window(s, st, 6'h00, 6'h00, 1'b1, 1'b0, 1'b1, -1, 0);
        tick();
        check("t2_fail", res_fail, 1);
        check("t2_fail_count", fail_count, 1);
        check("t2_first_fail_idx", first_fail_idx, 0);
        check("t2_any_fail", any_fail, 1);

        // 3: windows 1 and 2 fail
        do_clr();
        check("clr_first_fail_idx", first_fail_idx, 32'hFFFF);
        check("clr_any_fail", any_fail, 0);
        run_window(25'h0, 25'h0, 6'h11, 6'h11, 1'b1, 1'b1, 1'b1, -1, 0);
        run_window(25'h0, 25'h0, 6'h11, 6'h12, 1'b1, 1'b1, 1'b1, -1, 0);
        run_window(25'h0, 25'h1, 6'h11, 6'h11, 1'b1, 1'b1, 1'b1, -1, 0);
        tick();
        check("t3_pattern_count", pattern_count, 3);
        check("t3_fail_count", fail_count, 2);
        check("t3_first_fail_idx", first_fail_idx, 1);

        // 4: final unload without a capture cycle
        run_window(25'h0_00FF, 25'h0_00FF, 6'h00, 6'h3F, 1'b1, 1'b0, 1'b0, -1, 0);
        check("t4_not_yet", res_valid, 0);
        tick();
        check("t4_valid", res_valid, 1);
        check("t4_fail", res_fail, 0);
        check("t4_pattern_count", pattern_count, 4);

        // clr in the DONE cycle wins over the count update
        do_clr();
        run_window(25'h0, 25'h0, 6'h05, 6'h05, 1'b1, 1'b1, 1'b1, -1, 0);
        do_clr();
        check("clr_done_valid", res_valid, 0);
        check("clr_done_pattern_count", pattern_count, 0);

        // Random windows
        for (int w = 0; w < 40; w++) begin
            s  = FF'($urandom);
            st = s;
            if ($urandom_range(0, 3) == 0) begin
                idx = $urandom_range(0, FF - 1);
                st[idx] = ~st[idx];
            end
            cs = ($urandom_range(0, 3) != 0);
            cc = ($urandom_range(0, 4) != 0);
            cp = cc && ($urandom_range(0, 1) == 1);
            ep = OW'($urandom);
            pv = ($urandom_range(0, 3) == 0) ? OW'($urandom) : ep;
            ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, FF - 1)) : -1;
            ov = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0;
            run_window(s, st, ep, pv, cs, cp, cc, ab, ov);
            repeat ($urandom_range(0, 3)) tick();
        end
        repeat (3) tick();

        // 5: early capture after 10 bits
        do_clr();
        check("t5_proto_before", proto_err, 0);
        run_window(25'h0, 25'h0, 6'h00, 6'h00, 1'b0, 1'b0, 1'b1, 10, 0);
        check("t5_proto_err", proto_err, 1);
        tick();
        check("t5_valid", res_valid, 1);
        check("t5_fail", res_fail, 1);
        tick();
        check("t5_exp_ready", exp_ready, 1);
        NbarT = 1'b1;
        tick();
        NbarT = 1'b0;
        tick();
        check("t5_proto_sticky", proto_err, 1);
        check("t5_pattern_count", pattern_count, 1);

        // 6: reset in the middle of a shift
        send_record(25'h0, 6'h00, 1'b1, 1'b1, 1'b1);
        shift_bits(25'h0, 12);
        check("t6_exp_ready_shift", exp_ready, 0);
        rst_n = 1'b0;
        #1;
        check("t6_exp_ready", exp_ready, 1);
        check("t6_res_valid", res_valid, 0);
        check("t6_pattern_count", pattern_count, 0);
        check("t6_fail_count", fail_count, 0);
        check("t6_first_fail_idx", first_fail_idx, 32'hFFFF);
        check("t6_any_fail", any_fail, 0);
        check("t6_proto_err", proto_err, 0);
        NbarT = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        run_window(25'h1AB_CDEF, 25'h1AB_CDEF, 6'h15, 6'h15, 1'b1, 1'b1, 1'b1, -1, 0);
        tick();
        check("t6_after_fail", res_fail, 0);
        check("t6_after_pattern_count", pattern_count, 1);
        repeat (2) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
